predelay_line: RTL and testbench

PREDELAY_LINE -- requirements
Module: predelay_line

---
 rtl/predelay_line.sv | 113 +++++++++++
 tb/tb_predelay_line.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/predelay_line.sv
// rtl/predelay_line.sv - circular-buffer predelay with a three-state sample handshake
module predelay_line #(
   parameter int DATA_W = 24,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [23:0]       predelay_value,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready
);

   localparam int DEPTH = 2 ** ADDR_W;

   typedef enum logic [1:0] {IDLE, RD, OUT} state_t;

   state_t            state;
   state_t            state_nxt;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rd_data;
   logic [DATA_W-1:0] in_hold;
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] fill_count;
   logic [ADDR_W-1:0] d_req;
   logic [ADDR_W-1:0] rd_addr;
   logic              bypass;
   logic              zero_fill;
   logic              xfer;

   // Requests beyond the buffer saturate to the oldest readable slot.
   always_comb begin
      if (predelay_value >= 24'(DEPTH - 1))
         d_req = '1;
      else
         d_req = predelay_value[ADDR_W-1:0];
   end

   assign rd_addr = wr_ptr - d_req;

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      xfer      = 1'b0;
      case (state)
         IDLE: begin
            in_ready = ~reset;
            xfer     = in_valid & ~reset;
            if (xfer)
               state_nxt = RD;
         end
         RD: begin
            state_nxt = OUT;
         end
         OUT: begin
            out_valid = ~reset;
            if (out_ready)
               state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Memory carries no reset; fill_count alone decides whether stored data is trusted.
   always_ff @(posedge clk) begin
      if (xfer) begin
         mem[wr_ptr] <= in_data;
         rd_data     <= mem[rd_addr];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr     <= '0;
         fill_count <= '0;
         out_data   <= '0;
         in_hold    <= '0;
         bypass     <= 1'b0;
         zero_fill  <= 1'b0;
      end else begin
         if (xfer) begin
            wr_ptr    <= wr_ptr + 1'b1;
            bypass    <= (d_req == '0);
            zero_fill <= (fill_count < d_req);
            in_hold   <= in_data;
            if (fill_count != '1)
               fill_count <= fill_count + 1'b1;
         end
         if (state == RD) begin
            if (bypass)
               out_data <= in_hold;
            else if (zero_fill)
               out_data <= '0;
            else
               out_data <= rd_data;
         end
      end
   end

endmodule

// File: tb/tb_predelay_line.sv
// tb/tb_predelay_line.sv - randomized self-checking bench for predelay_line
module tb_predelay_line;

   localparam int DEPTH = 1024;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [23:0] in_data = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [23:0] predelay_value = '0;
   logic [23:0] out_data;
   logic        out_valid;
   logic        out_ready = 1'b1;

   int          checks = 0;
   int          failures = 0;
   logic [23:0] hist [$];

   predelay_line #(.DATA_W(24), .ADDR_W(10)) dut (
      .clk            (clk),
      .reset          (reset),
      .in_data        (in_data),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .predelay_value (predelay_value),
      .out_data       (out_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready)
   );

   always #5 clk = ~clk;

   // Output of the k-th sample since reset is sample k-d, or zero before it existed.
   task automatic xfer(input logic [23:0] data, input logic [23:0] pdv, input logic [23:0] pdv_mid,
                       input int hold, output logic [23:0] got);
      int          k;
      int          d;
      int          lat;
      bit          ok;
      logic [23:0] exp_v;
      logic [23:0] first;
      got = '0;
      out_ready = (hold == 0);
      ok = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (in_ready === 1'b1) begin
            ok = 1;
            break;
         end
      end
      if (!ok) begin
         checks++;
         failures++;
         $display("FAIL in_ready_timeout: in_ready=%b required 1", in_ready);
         return;
      end
      k = hist.size();
      d = (pdv >= DEPTH) ? DEPTH - 1 : int'(pdv);
      exp_v = (d == 0) ? data : ((k < d) ? 24'd0 : hist[k - d]);
      hist.push_back(data);
      in_data = data;
      predelay_value = pdv;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      predelay_value = pdv_mid;
      lat = 0;
      ok = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         lat++;
         if (out_valid === 1'b1) begin
            ok = 1;
            break;
         end
      end
      checks++;
      if (!ok || lat != 2) begin
         failures++;
         $display("FAIL latency: cycles=%0d seen=%0b required 2", lat, ok);
      end
      first = out_data;
      if (hold > 0) begin
         in_data = data ^ 24'hABCDEF;
         in_valid = 1'b1;
         repeat (hold) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== first) begin
               failures++;
               $display("FAIL hold: out_valid=%b in_ready=%b out_data=%h required 1 0 %h",
                        out_valid, in_ready, out_data, first);
            end
         end
         in_valid = 1'b0;
         out_ready = 1'b1;
      end
      checks++;
      if (first !== exp_v) begin
         failures++;
         $display("FAIL data: sample=%0d d=%0d out_data=%h required %h", k, d, first, exp_v);
      end
      got = first;
      @(posedge clk);
      #1;
      out_ready = 1'b1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      hist.delete();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (in_ready !== 1'b0) begin
         failures++;
         $display("FAIL reset_in_ready: got %b required 0", in_ready);
      end
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_out_valid: got %b required 0", out_valid);
      end
      checks++;
      if (out_data !== 24'd0) begin
         failures++;
         $display("FAIL reset_out_data: got %h required 0", out_data);
      end
      reset = 1'b0;
      hist.delete();
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL post_reset_in_ready: got %b required 1", in_ready);
      end
   endtask

   task automatic test_zero_delay();
      logic [23:0] got;
      do_reset();
      for (int i = 1; i <= 3; i++) begin
         xfer(24'(i), 24'd0, 24'd0, 0, got);
      end
   endtask

   task automatic test_delay3();
      logic [23:0] got;
      do_reset();
      for (int i = 1; i <= 5; i++) begin
         xfer(24'(10 * i), 24'd3, 24'd3, 0, got);
      end
   endtask

   task automatic test_backpressure();
      logic [23:0] got;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         xfer(24'($urandom), 24'd1, 24'd1, (i == 2) ? 10 : 0, got);
      end
   endtask

   task automatic test_delay_change();
      logic [23:0] got;
      do_reset();
      for (int i = 0; i < 6; i++) begin
         xfer(24'($urandom), 24'd2, 24'd2, 0, got);
      end
      xfer(24'($urandom), 24'd2, 24'd4, 0, got);
      xfer(24'($urandom), 24'd4, 24'd4, 0, got);
      xfer(24'($urandom), 24'd4, 24'd4, 0, got);
   endtask

   task automatic test_random();
      logic [23:0] got;
      logic [23:0] pdv;
      do_reset();
      for (int i = 0; i < 60; i++) begin
         pdv = ($urandom_range(0, 9) == 0) ? 24'd2000 : 24'($urandom_range(0, 12));
         xfer(24'($urandom), pdv, 24'($urandom_range(0, 12)),
              ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0, got);
      end
   endtask

   task automatic test_saturation();
      logic [23:0] got;
      do_reset();
      for (int k = 0; k <= 1024; k++) begin
         xfer(24'(k), 24'd5000, 24'd5000, 0, got);
         if (k == 1023) begin
            checks++;
            if (got !== 24'd0) begin
               failures++;
               $display("FAIL sat_1024th: got %h required 0", got);
            end
         end
         if (k == 1024) begin
            checks++;
            if (got !== 24'd1) begin
               failures++;
               $display("FAIL sat_1025th: got %h required 1", got);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [23:0] got;
      logic [23:0] a;
      bit          ok;
      do_reset();
      for (int i = 0; i < 8; i++) begin
         xfer(24'($urandom), 24'd2, 24'd2, 0, got);
      end
      out_ready = 1'b0;
      ok = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (in_ready === 1'b1) begin
            ok = 1;
            break;
         end
      end
      in_data = 24'h55AA55;
      predelay_value = 24'd2;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      for (int i = 0; i < 10 && ok; i++) begin
         @(negedge clk);
         if (out_valid === 1'b1)
            break;
      end
      checks++;
      if (!ok || out_valid !== 1'b1) begin
         failures++;
         $display("FAIL mid_reach_out: out_valid=%b required 1", out_valid);
      end
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL mid_reset_out_valid: got %b required 0", out_valid);
      end
      reset = 1'b0;
      out_ready = 1'b1;
      hist.delete();
      a = 24'($urandom);
      xfer(a, 24'd2, 24'd2, 0, got);
      checks++;
      if (got !== 24'd0) begin
         failures++;
         $display("FAIL mid_first_zero: got %h required 0", got);
      end
      xfer(24'($urandom), 24'd2, 24'd2, 0, got);
      checks++;
      if (got !== 24'd0) begin
         failures++;
         $display("FAIL mid_second_zero: got %h required 0", got);
      end
      xfer(24'($urandom), 24'd2, 24'd2, 0, got);
      checks++;
      if (got !== a) begin
         failures++;
         $display("FAIL mid_third: got %h required %h", got, a);
      end
   endtask

   initial begin
      test_reset();
      test_zero_delay();
      test_delay3();
      test_backpressure();
      test_delay_change();
      test_random();
      test_reset_mid();
      test_saturation();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
